// File: rtl/spi_responder.sv
// ---------------------------------------------------------------------------
// spi_responder
//   SPI slave used as the far end of the if_spi / if_spi_multi masters for
//   loopback and self-test.  Every SPI input is oversampled in the sys_clk
//   domain.  Received bits are assembled MSB-first into bytes.  Reply bytes
//   come from a show-ahead FIFO and are shifted out MSB-first.
//
// Parameters
//   CPOL            SCLK idle level
//   CPHA            0: sample on leading edge, 1: sample on trailing edge
//   BYTES_PER_FRAME expected bytes per n_cs-low frame, 0 = unlimited
//   FILL_BYTE       byte sent when the reply FIFO is empty or exhausted
//
// Ports
//   sys_clk    system clock, at least 4x SCLK
//   rst        asynchronous active-high reset
//   n_cs       chip select from master (async)
//   sclk       serial clock from master (async)
//   mosi       serial data from master (async)
//   miso       serial data to master
//   miso_oe    high while a frame is active
//   rx_data    last complete received byte
//   rx_valid   one-cycle strobe when rx_data updates
//   frame_end  one-cycle strobe when an active frame closes
//   frame_err  sticky frame error, cleared at the next frame start
//   tx_data    reply FIFO head (show-ahead)
//   tx_empty   reply FIFO empty
//   tx_rdreq   one-cycle FIFO pop
// ---------------------------------------------------------------------------
module spi_responder #(
  parameter bit          CPOL            = 1'b0,
  parameter bit          CPHA            = 1'b0,
  parameter int unsigned BYTES_PER_FRAME = 2,
  parameter logic [7:0]  FILL_BYTE       = 8'hFF
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       n_cs,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_end,
  output logic       frame_err,
  input  logic [7:0] tx_data,
  input  logic       tx_empty,
  output logic       tx_rdreq
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  // Bits [1:0] form the synchroniser, bit [2] is the edge-detect history.
  // The chip-select chain resets low, so a frame that is already running when
  // reset releases produces no falling edge until n_cs has been seen high.
  logic [2:0] cs_sync;
  logic [2:0] sclk_sync;
  logic [1:0] mosi_sync;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cs_sync   <= 3'b000;
      sclk_sync <= {3{CPOL}};
      mosi_sync <= 2'b00;
    end else begin
      cs_sync   <= {cs_sync[1:0], n_cs};
      sclk_sync <= {sclk_sync[1:0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
    end
  end

  logic cs_fall, cs_rise, lead_edge, trail_edge, sample_edge, shift_edge;

  assign cs_fall     = cs_sync[2] & ~cs_sync[1];
  assign cs_rise     = ~cs_sync[2] & cs_sync[1];
  assign lead_edge   = (sclk_sync[2] == CPOL) && (sclk_sync[1] != CPOL);
  assign trail_edge  = (sclk_sync[2] != CPOL) && (sclk_sync[1] == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;

  logic [0:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;
  logic [7:0] shift_rx;
  logic [7:0] shift_tx;
  logic       skip_shift;

  // Reply byte selection.  load_index is the position in the frame of the
  // byte about to be loaded; positions past the frame budget send the fill
  // byte without touching the FIFO.
  logic [8:0] load_index;
  logic       pop_ok;
  logic [7:0] load_byte;
  logic [7:0] rx_next;
  logic       byte_done;
  logic [2:0] bit_cnt_next;
  logic [7:0] byte_cnt_next;
  logic       err_next;

  always_comb begin
    load_index    = (state == IDLE) ? 9'd0 : ({1'b0, byte_cnt} + 9'd1);
    pop_ok        = ((BYTES_PER_FRAME == 0) || ({23'd0, load_index} < BYTES_PER_FRAME))
                    && !tx_empty;
    load_byte     = pop_ok ? tx_data : FILL_BYTE;
    rx_next       = {shift_rx[6:0], mosi_sync[1]};
    byte_done     = sample_edge && (bit_cnt == 3'd7);
    bit_cnt_next  = sample_edge ? (bit_cnt + 3'd1) : bit_cnt;
    byte_cnt_next = (byte_done && (byte_cnt != 8'hFF)) ? (byte_cnt + 8'd1) : byte_cnt;
    // Uses the post-sample counts so a byte completing on the same cycle as
    // the n_cs rise is counted.
    err_next      = (bit_cnt_next != 3'd0) ||
                    ((BYTES_PER_FRAME != 0) && ({24'd0, byte_cnt_next} != BYTES_PER_FRAME));
  end

  // Frame state machine.  Within one cycle the sample is handled first, then
  // a possible frame close, otherwise a next-byte load.  skip_shift marks a
  // freshly loaded byte whose MSB is already on miso: the next shift edge
  // just re-drives the MSB instead of advancing.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      byte_cnt   <= 8'd0;
      shift_rx   <= 8'd0;
      shift_tx   <= 8'd0;
      skip_shift <= 1'b0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      rx_data    <= 8'd0;
      rx_valid   <= 1'b0;
      frame_end  <= 1'b0;
      frame_err  <= 1'b0;
      tx_rdreq   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_end <= 1'b0;
      tx_rdreq  <= 1'b0;
      if (state == IDLE) begin
        if (cs_fall) begin
          state      <= ACTIVE;
          bit_cnt    <= 3'd0;
          byte_cnt   <= 8'd0;
          shift_rx   <= 8'd0;
          frame_err  <= 1'b0;
          shift_tx   <= load_byte;
          miso       <= load_byte[7];
          tx_rdreq   <= pop_ok;
          skip_shift <= CPHA;
          miso_oe    <= 1'b1;
        end
      end else begin
        if (sample_edge) begin
          shift_rx <= rx_next;
          bit_cnt  <= bit_cnt_next;
          byte_cnt <= byte_cnt_next;
          if (byte_done) begin
            rx_data  <= rx_next;
            rx_valid <= 1'b1;
          end
        end
        if (shift_edge) begin
          if (skip_shift) begin
            miso       <= shift_tx[7];
            skip_shift <= 1'b0;
          end else begin
            miso     <= shift_tx[6];
            shift_tx <= {shift_tx[6:0], 1'b0};
          end
        end
        if (cs_rise) begin
          state     <= IDLE;
          frame_end <= 1'b1;
          frame_err <= err_next;
          miso_oe   <= 1'b0;
          miso      <= 1'b0;
        end else if (byte_done) begin
          shift_tx   <= load_byte;
          miso       <= load_byte[7];
          tx_rdreq   <= pop_ok;
          skip_shift <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_responder
//   Four responder instances in different modes, each with its own bus-master
//   model and reply FIFO:
//     d0: CPOL=0 CPHA=0 BYTES_PER_FRAME=2
//     d1: CPOL=0 CPHA=1 BYTES_PER_FRAME=2
//     d2: CPOL=1 CPHA=1 BYTES_PER_FRAME=2
//     d3: CPOL=0 CPHA=0 BYTES_PER_FRAME=0
//   Expected behaviour is computed per frame from the bytes sent, bit count,
//   frame budget and FIFO contents; a background monitor checks every
//   strobe against it.
// ---------------------------------------------------------------------------
module tb_spi_responder;

  localparam int HALF = 40;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic [3:0] n_cs_v, sclk_v, mosi_v;
  logic [3:0] miso_v, miso_oe_v, rx_valid_v, frame_end_v, frame_err_v, tx_rdreq_v, tx_empty_v;
  logic [7:0] rx_data_a [4];
  logic [7:0] tx_data_a [4];

  logic cpol_of [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic cpha_of [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  int   bpf_of  [4] = '{2, 2, 2, 0};

  logic [7:0] fifo_mem [4][8];
  int         fifo_wr  [4] = '{0, 0, 0, 0};
  int         fifo_rd  [4] = '{0, 0, 0, 0};

  logic [7:0] exp_rx  [4][16];
  int         exp_wr  [4] = '{0, 0, 0, 0};
  int         exp_rd  [4] = '{0, 0, 0, 0};
  logic       exp_err [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  int         fe_exp  [4] = '{0, 0, 0, 0};
  int         fe_seen [4] = '{0, 0, 0, 0};
  int         pops_seen [4] = '{0, 0, 0, 0};

  logic [63:0] cap_got, cap_exp;
  int          full_exp, pops_exp, pops_got;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 sys_clk = ~sys_clk;

  // Show-ahead reply FIFOs popped by the responders
  always_comb begin
    for (int d = 0; d < 4; d++) begin
      tx_empty_v[d] = (fifo_rd[d] >= fifo_wr[d]);
      tx_data_a[d]  = fifo_mem[d][fifo_rd[d][2:0]];
    end
  end

  always @(posedge sys_clk) begin
    for (int d = 0; d < 4; d++)
      if (tx_rdreq_v[d] && (fifo_rd[d] < fifo_wr[d])) fifo_rd[d] <= fifo_rd[d] + 1;
  end

  spi_responder #(.CPOL(1'b0), .CPHA(1'b0), .BYTES_PER_FRAME(2), .FILL_BYTE(8'hFF)) dut0 (
    .sys_clk(sys_clk), .rst(rst), .n_cs(n_cs_v[0]), .sclk(sclk_v[0]), .mosi(mosi_v[0]),
    .miso(miso_v[0]), .miso_oe(miso_oe_v[0]), .rx_data(rx_data_a[0]), .rx_valid(rx_valid_v[0]),
    .frame_end(frame_end_v[0]), .frame_err(frame_err_v[0]), .tx_data(tx_data_a[0]),
    .tx_empty(tx_empty_v[0]), .tx_rdreq(tx_rdreq_v[0]));

  spi_responder #(.CPOL(1'b0), .CPHA(1'b1), .BYTES_PER_FRAME(2), .FILL_BYTE(8'hFF)) dut1 (
    .sys_clk(sys_clk), .rst(rst), .n_cs(n_cs_v[1]), .sclk(sclk_v[1]), .mosi(mosi_v[1]),
    .miso(miso_v[1]), .miso_oe(miso_oe_v[1]), .rx_data(rx_data_a[1]), .rx_valid(rx_valid_v[1]),
    .frame_end(frame_end_v[1]), .frame_err(frame_err_v[1]), .tx_data(tx_data_a[1]),
    .tx_empty(tx_empty_v[1]), .tx_rdreq(tx_rdreq_v[1]));

  spi_responder #(.CPOL(1'b1), .CPHA(1'b1), .BYTES_PER_FRAME(2), .FILL_BYTE(8'hFF)) dut2 (
    .sys_clk(sys_clk), .rst(rst), .n_cs(n_cs_v[2]), .sclk(sclk_v[2]), .mosi(mosi_v[2]),
    .miso(miso_v[2]), .miso_oe(miso_oe_v[2]), .rx_data(rx_data_a[2]), .rx_valid(rx_valid_v[2]),
    .frame_end(frame_end_v[2]), .frame_err(frame_err_v[2]), .tx_data(tx_data_a[2]),
    .tx_empty(tx_empty_v[2]), .tx_rdreq(tx_rdreq_v[2]));

  spi_responder #(.CPOL(1'b0), .CPHA(1'b0), .BYTES_PER_FRAME(0), .FILL_BYTE(8'hFF)) dut3 (
    .sys_clk(sys_clk), .rst(rst), .n_cs(n_cs_v[3]), .sclk(sclk_v[3]), .mosi(mosi_v[3]),
    .miso(miso_v[3]), .miso_oe(miso_oe_v[3]), .rx_data(rx_data_a[3]), .rx_valid(rx_valid_v[3]),
    .frame_end(frame_end_v[3]), .frame_err(frame_err_v[3]), .tx_data(tx_data_a[3]),
    .tx_empty(tx_empty_v[3]), .tx_rdreq(tx_rdreq_v[3]));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  task automatic cs_low(input int d);
    n_cs_v[d] = 1'b0;
    #(2 * HALF);
  endtask

  task automatic cs_high(input int d);
    #(HALF);
    n_cs_v[d] = 1'b1;
    #(3 * HALF);
  endtask

  // One SCLK period as the master sees it; cap is miso at the master's
  // sample edge.
  task automatic send_bit(input int d, input logic b, output logic cap);
    if (cpha_of[d]) begin
      sclk_v[d] = ~cpol_of[d];
      mosi_v[d] = b;
      #(HALF);
      sclk_v[d] = cpol_of[d];
      cap = miso_v[d];
      #(HALF);
    end else begin
      mosi_v[d] = b;
      #(HALF);
      sclk_v[d] = ~cpol_of[d];
      cap = miso_v[d];
      #(HALF);
      sclk_v[d] = cpol_of[d];
    end
  endtask

  // Predicts the frame outcome, then runs it.  Reply byte k comes from the
  // FIFO when k is inside the frame budget and the FIFO still holds an entry;
  // otherwise it is the fill byte.  One byte is loaded at frame start plus one
  // per completed received byte.
  task automatic applyStimulus(input int d, input logic [63:0] data, input int nbits);
    int avail, pops_before;
    logic b;
    full_exp = nbits / 8;
    avail    = fifo_wr[d] - fifo_rd[d];
    cap_exp  = '0;
    pops_exp = 0;
    for (int k = 0; k <= full_exp; k++) begin
      logic [7:0] rb;
      if (((bpf_of[d] == 0) || (k < bpf_of[d])) && (k < avail)) begin
        rb = fifo_mem[d][(fifo_rd[d] + k) % 8];
        pops_exp++;
      end else begin
        rb = 8'hFF;
      end
      if (k < full_exp) cap_exp[63 - 8 * k -: 8] = rb;
    end
    for (int k = 0; k < full_exp; k++) begin
      exp_rx[d][exp_wr[d] % 16] = data[63 - 8 * k -: 8];
      exp_wr[d] = exp_wr[d] + 1;
    end
    exp_err[d] = ((nbits % 8) != 0) || ((bpf_of[d] != 0) && (full_exp != bpf_of[d]));
    fe_exp[d]  = fe_exp[d] + 1;
    pops_before = pops_seen[d];
    cap_got = '0;
    cs_low(d);
    for (int i = 0; i < nbits; i++) begin
      send_bit(d, data[63 - i], b);
      cap_got[63 - i] = b;
    end
    cs_high(d);
    pops_got = pops_seen[d] - pops_before;
  endtask

  task automatic checkOutput(input int d);
    for (int k = 0; k < full_exp; k++)
      check($sformatf("miso_byte%0d_d%0d", k, d), {56'd0, cap_got[63 - 8 * k -: 8]},
            {56'd0, cap_exp[63 - 8 * k -: 8]});
    check($sformatf("pops_d%0d", d), pops_got, pops_exp);
    check($sformatf("frame_end_count_d%0d", d), fe_seen[d], fe_exp[d]);
    check($sformatf("rx_all_seen_d%0d", d), exp_rd[d], exp_wr[d]);
    check($sformatf("miso_oe_idle_d%0d", d), miso_oe_v[d], 0);
  endtask

  task automatic check_reset_values(input int d);
    check($sformatf("rst_miso_d%0d", d), miso_v[d], 0);
    check($sformatf("rst_miso_oe_d%0d", d), miso_oe_v[d], 0);
    check($sformatf("rst_rx_data_d%0d", d), rx_data_a[d], 0);
    check($sformatf("rst_rx_valid_d%0d", d), rx_valid_v[d], 0);
    check($sformatf("rst_frame_end_d%0d", d), frame_end_v[d], 0);
    check($sformatf("rst_frame_err_d%0d", d), frame_err_v[d], 0);
    check($sformatf("rst_tx_rdreq_d%0d", d), tx_rdreq_v[d], 0);
  endtask

  initial begin
    logic b;
    int   fe_before;
    rst = 1'b1;
    for (int d = 0; d < 4; d++) begin
      n_cs_v[d] = 1'b1;
      sclk_v[d] = cpol_of[d];
      mosi_v[d] = 1'b0;
      for (int k = 0; k < 8; k++) fifo_mem[d][k] = 8'h00;
    end
    fifo_mem[1][0] = 8'h5A;
    fifo_mem[1][1] = 8'hC3;
    fifo_wr[1]     = 2;

    // Strobe monitor: every rx_valid, tx_rdreq and frame_end is checked
    fork
      forever begin
        @(negedge sys_clk);
        if (!rst) begin
          for (int d = 0; d < 4; d++) begin
            if (rx_valid_v[d]) begin
              if (exp_rd[d] < exp_wr[d]) begin
                check($sformatf("rx_data_d%0d", d), rx_data_a[d], exp_rx[d][exp_rd[d] % 16]);
                exp_rd[d] = exp_rd[d] + 1;
              end else begin
                check($sformatf("rx_valid_unexpected_d%0d", d), rx_valid_v[d], 0);
              end
            end
            if (tx_rdreq_v[d]) begin
              check($sformatf("rdreq_while_empty_d%0d", d), tx_empty_v[d], 0);
              pops_seen[d] = pops_seen[d] + 1;
            end
            if (frame_end_v[d]) begin
              check($sformatf("frame_err_d%0d", d), frame_err_v[d], exp_err[d]);
              fe_seen[d] = fe_seen[d] + 1;
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge sys_clk);
    for (int d = 0; d < 4; d++) check_reset_values(d);
    rst = 1'b0;
    repeat (10) @(negedge sys_clk);

    $display("[TB] mode 0 receive");
    applyStimulus(0, 64'hA53C_0000_0000_0000, 16);
    checkOutput(0);
    check("t1_last_rx", rx_data_a[0], 8'h3C);
    check("t1_frame_end_lit", fe_seen[0], 1);
    check("t1_frame_err_lit", frame_err_v[0], 0);

    $display("[TB] mode 1 reply");
    applyStimulus(1, 64'h1234_0000_0000_0000, 16);
    checkOutput(1);
    check("t2_miso_lit", cap_got[63:48], 16'h5AC3);
    check("t2_pops_lit", pops_got, 2);
    check("t2_last_rx", rx_data_a[1], 8'h34);

    $display("[TB] empty fifo mode 3");
    applyStimulus(2, 64'hF00F_0000_0000_0000, 16);
    checkOutput(2);
    check("t3_miso_lit", cap_got[63:48], 16'hFFFF);
    check("t3_pops_lit", pops_got, 0);

    $display("[TB] short frame");
    applyStimulus(0, 64'h96B0_0000_0000_0000, 12);
    checkOutput(0);
    check("t4_rx_lit", rx_data_a[0], 8'h96);
    check("t4_err_sticky", frame_err_v[0], 1);

    $display("[TB] unlimited frame");
    applyStimulus(3, 64'h0102_0304_0500_0000, 40);
    checkOutput(3);
    check("t5_last_rx", rx_data_a[3], 8'h05);
    check("t5_err_lit", frame_err_v[3], 0);

    $display("[TB] reset mid-frame");
    fe_before = fe_seen[0];
    cs_low(0);
    check("t6_err_cleared", frame_err_v[0], 0);
    check("t6_miso_oe_active", miso_oe_v[0], 1);
    for (int i = 0; i < 4; i++) send_bit(0, i[0], b);
    rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    check_reset_values(0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(0, 1'b1, b);
    cs_high(0);
    check("t6_no_frame_end", fe_seen[0], fe_before);
    check("t6_miso_oe_after", miso_oe_v[0], 0);
    fe_exp[0] = fe_seen[0];
    applyStimulus(0, 64'h8100_0000_0000_0000, 8);
    checkOutput(0);
    check("t6_rx_lit", rx_data_a[0], 8'h81);

    repeat (20) @(negedge sys_clk);
    for (int d = 0; d < 4; d++)
      check($sformatf("final_rx_drain_d%0d", d), exp_rd[d], exp_wr[d]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
